fpu_ss_mem_responder: RTL and testbench
=======================================

# fpu_ss_mem_responder

Core-side responder for the coprocessor memory request/result interface. Accepts single-beat `x_mem` requests from the FPU subsystem, turns them into OBI-style data-bus transactions (req/gnt address phase, rvalid response phase), and returns exactly one `x_mem_result` pulse per request, in order. It sits between the FPU subsystem controller's memory port and the core's data bus, tracking up to `MAX_OUTSTANDING` granted transactions.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, request/bus address width
- `DATA_WIDTH`, 32, data width; `DATA_WIDTH/8` byte enables
- `ID_WIDTH`, 4, instruction id width
- `MAX_OUTSTANDING`, 2, granted-but-unanswered bus transactions (≥1)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous reset, active-high.
- `x_mem_valid_i` in 1: request valid.
- `x_mem_ready_o` out 1: request accepted when high with valid.
- `x_mem_req_id_i` in ID_WIDTH: instruction id.
- `x_mem_req_addr_i` in ADDR_WIDTH: byte address.
- `x_mem_req_we_i` in 1: 1 store, 0 load.
- `x_mem_req_be_i` in DATA_WIDTH/8: byte enables.
- `x_mem_req_wdata_i` in DATA_WIDTH: store data.
- `x_mem_req_last_i` in 1: last beat; always 1 from the initiator, ignored.
- `x_mem_req_spec_i` in 1: speculative flag; ignored, all requests performed.
- `x_mem_result_valid_o` out 1: one-cycle result pulse, no backpressure.
- `x_mem_result_id_o` out ID_WIDTH: id of the completed request.
- `x_mem_result_rdata_o` out DATA_WIDTH: load data; 0 for stores.
- `x_mem_result_err_o` out 1: bus error on this transaction.
- `data_req_o` out 1: bus address-phase request.
- `data_gnt_i` in 1: bus grant.
- `data_addr_o` out ADDR_WIDTH: bus address.
- `data_we_o` out 1: bus write enable.
- `data_be_o` out DATA_WIDTH/8: bus byte enables.
- `data_wdata_o` out DATA_WIDTH: bus write data.
- `data_rvalid_i` in 1: bus response valid.
- `data_rdata_i` in DATA_WIDTH: bus read data.
- `data_err_i` in 1: bus error, qualified by rvalid.
- `busy_o` out 1: request held or any transaction outstanding.
- `protocol_err_o` out 1: sticky; set on rvalid with no outstanding transaction.

## Operation
- FSM states IDLE, REQ.
- IDLE:
  - `x_mem_ready_o = (count < MAX_OUTSTANDING)`.
  - On handshake, capture addr/we/be/wdata/id into the hold register and go to REQ.
- REQ:
  - `data_req_o = 1`; bus outputs driven from the hold register and stable until grant.
  - On `data_gnt_i`: push {id, we} into the metadata FIFO, increment `count`, return to IDLE.
  - `x_mem_ready_o = 0` in REQ.
- Response path:
  - On `data_rvalid_i` with `count > 0`: pop the FIFO head and register result outputs for the next cycle.
  - Result outputs: valid=1, id=head.id, rdata=(head.we ? 0 : `data_rdata_i`), err=`data_err_i`.
  - Decrement `count`.
- Grant and rvalid in the same cycle: push and pop both occur; `count` unchanged.
- FIFO full is impossible by construction, because acceptance is gated by `count`.
- Unexpected response (rvalid with `count == 0`): no result is produced and `protocol_err_o` is set until reset.
- `count` width is `$clog2(MAX_OUTSTANDING+1)`; it never wraps.
- `busy_o = (state == REQ) | (count != 0)`.

## Timing
- Reset values:
  - state IDLE, `count` 0, FIFO empty.
  - `data_req_o`, `x_mem_result_valid_o`, `x_mem_result_err_o`, `protocol_err_o`, `busy_o` all 0.
  - result id/rdata 0; `x_mem_ready_o` 1 after reset.
- Reset mid-operation discards the held request and all outstanding metadata. A late rvalid arriving afterwards sets `protocol_err_o`.
- Request latency: handshake at cycle t, then `data_req_o` high from t+1. With grant at t+1, the block is back in IDLE at t+2, so maximum acceptance rate is one request per 2 cycles.
- Response latency: `data_rvalid_i` at cycle r gives `x_mem_result_valid_o` at r+1, high for exactly one cycle.
- Results are returned in grant order.

## Structure
- Shared package `fpu_ss_pkg` gets `mem_resp_meta_t` {id, we}. The widths there are fixed at the package's id width, which is 4.
- Sub-module `fpu_ss_mem_meta_fifo`:
  - Synchronous FIFO of `mem_resp_meta_t`, depth `MAX_OUTSTANDING`.
  - Ports push/pop/full/empty.
  - Simultaneous push and pop allowed when non-empty.

## Test plan
- Load: request id=3, addr=0x100, grant immediately, rvalid 2 cycles later with rdata=0xDEADBEEF → one result pulse, id=3, rdata=0xDEADBEEF, err=0.
- Store with gnt delayed 4 cycles: request id=5, be=0xF → addr/we/be/wdata stable for all 4 REQ cycles, `x_mem_ready_o`=0 throughout, result rdata=0.
- MAX_OUTSTANDING=2: three back-to-back requests, no rvalid → third held off (`x_mem_ready_o`=0 with count=2) until first rvalid. Results return ids in order.
- Grant of request B in the same cycle as rvalid for request A → count stays 1, result id=A, next rvalid yields id=B.
- rvalid with `data_err_i`=1 → result err=1. Spurious rvalid when idle → no result pulse, `protocol_err_o`=1 until `rst_i`.
- Assert `rst_i` while in REQ with one outstanding → next cycle `data_req_o`=0, `busy_o`=0, `x_mem_ready_o`=1. A following rvalid sets `protocol_err_o`.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Shared FPU subsystem types: per-transaction metadata carried from the bus grant to the response.
package fpu_ss_pkg;

  localparam int unsigned FPU_SS_ID_W = 4;

  typedef struct packed {
    logic [FPU_SS_ID_W-1:0] id;
    logic                   we;
  } mem_resp_meta_t;

  typedef enum logic [0:0] {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_REQ  = 1'b1
  } mem_resp_state_e;

endpackage

// File: rtl/fpu_ss_mem_meta_fifo.sv
// In-order FIFO of granted-transaction metadata; the head is read combinationally.
// Push and pop may coincide while non-empty; the depth matches the outstanding limit.
module fpu_ss_mem_meta_fifo
  import fpu_ss_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  mem_resp_meta_t push_dat_i,
  input  logic           pop_i,
  output mem_resp_meta_t pop_dat_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  mem_resp_meta_t mem_q [DEPTH];
  mem_resp_meta_t mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fpu_ss_mem_responder.sv
// Bridges x_mem requests onto an OBI-style data bus and returns one in-order result per request.
// Bus request follows the handshake by one cycle; result follows rvalid by one cycle; results are never stalled.
module fpu_ss_mem_responder
  import fpu_ss_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    x_mem_valid_i,
  output logic                    x_mem_ready_o,
  input  logic [ID_WIDTH-1:0]     x_mem_req_id_i,
  input  logic [ADDR_WIDTH-1:0]   x_mem_req_addr_i,
  input  logic                    x_mem_req_we_i,
  input  logic [DATA_WIDTH/8-1:0] x_mem_req_be_i,
  input  logic [DATA_WIDTH-1:0]   x_mem_req_wdata_i,
  input  logic                    x_mem_req_last_i,
  input  logic                    x_mem_req_spec_i,
  output logic                    x_mem_result_valid_o,
  output logic [ID_WIDTH-1:0]     x_mem_result_id_o,
  output logic [DATA_WIDTH-1:0]   x_mem_result_rdata_o,
  output logic                    x_mem_result_err_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i,
  output logic                    busy_o,
  output logic                    protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  mem_resp_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    res_vld_q, res_vld_d, res_err_q, res_err_d;
  logic [ID_WIDTH-1:0]     res_id_q, res_id_d;
  logic [DATA_WIDTH-1:0]   res_rdata_q, res_rdata_d;
  logic                    prot_err_q, prot_err_d;
  logic                    push, pop, fifo_full, fifo_empty;
  mem_resp_meta_t          push_meta, head_meta;
  logic                    unused_inputs;

  // last/spec carry no information for single-beat, always-performed requests.
  assign unused_inputs = ^{x_mem_req_last_i, x_mem_req_spec_i, fifo_full, fifo_empty};

  assign x_mem_ready_o        = (state_q == MEM_ST_IDLE) && (count_q < CNT_W'(MAX_OUTSTANDING));
  assign data_req_o           = (state_q == MEM_ST_REQ);
  assign data_addr_o          = addr_q;
  assign data_we_o            = we_q;
  assign data_be_o            = be_q;
  assign data_wdata_o         = wdata_q;
  assign busy_o               = (state_q == MEM_ST_REQ) || (count_q != '0);
  assign protocol_err_o       = prot_err_q;
  assign x_mem_result_valid_o = res_vld_q;
  assign x_mem_result_id_o    = res_id_q;
  assign x_mem_result_rdata_o = res_rdata_q;
  assign x_mem_result_err_o   = res_err_q;
  assign push_meta.id         = FPU_SS_ID_W'(id_q);
  assign push_meta.we         = we_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    id_d        = id_q;
    res_vld_d   = 1'b0;
    res_id_d    = res_id_q;
    res_rdata_d = res_rdata_q;
    res_err_d   = res_err_q;
    prot_err_d  = prot_err_q;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        if (x_mem_valid_i && x_mem_ready_o) begin
          addr_d  = x_mem_req_addr_i;
          we_d    = x_mem_req_we_i;
          be_d    = x_mem_req_be_i;
          wdata_d = x_mem_req_wdata_i;
          id_d    = x_mem_req_id_i;
          state_d = MEM_ST_REQ;
        end
      end
      default: begin
        if (data_gnt_i) begin
          push    = 1'b1;
          state_d = MEM_ST_IDLE;
        end
      end
    endcase
    if (data_rvalid_i) begin
      if (count_q != '0) begin
        pop         = 1'b1;
        res_vld_d   = 1'b1;
        res_id_d    = ID_WIDTH'(head_meta.id);
        res_rdata_d = head_meta.we ? '0 : data_rdata_i;
        res_err_d   = data_err_i;
      end else begin
        prot_err_d = 1'b1;
      end
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= MEM_ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      id_q        <= '0;
      count_q     <= '0;
      res_vld_q   <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
      prot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      count_q     <= count_d;
      res_vld_q   <= res_vld_d;
      res_id_q    <= res_id_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
      prot_err_q  <= prot_err_d;
    end
  end

  fpu_ss_mem_meta_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_meta_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .push_dat_i(push_meta),
    .pop_i     (pop),
    .pop_dat_o (head_meta),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_fpu_ss_mem_responder.sv
// Directed stimulus with a result scoreboard; a negedge monitor compares every result pulse.
module tb_fpu_ss_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_mem_valid_i, x_mem_ready_o;
  logic [3:0]  x_mem_req_id_i;
  logic [31:0] x_mem_req_addr_i;
  logic        x_mem_req_we_i;
  logic [3:0]  x_mem_req_be_i;
  logic [31:0] x_mem_req_wdata_i;
  logic        x_mem_req_last_i, x_mem_req_spec_i;
  logic        x_mem_result_valid_o;
  logic [3:0]  x_mem_result_id_o;
  logic [31:0] x_mem_result_rdata_o;
  logic        x_mem_result_err_o;
  logic        data_req_o, data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i, busy_o, protocol_err_o;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  fpu_ss_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
    .x_mem_req_id_i(x_mem_req_id_i), .x_mem_req_addr_i(x_mem_req_addr_i),
    .x_mem_req_we_i(x_mem_req_we_i), .x_mem_req_be_i(x_mem_req_be_i),
    .x_mem_req_wdata_i(x_mem_req_wdata_i), .x_mem_req_last_i(x_mem_req_last_i),
    .x_mem_req_spec_i(x_mem_req_spec_i),
    .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_id_o(x_mem_result_id_o),
    .x_mem_result_rdata_o(x_mem_result_rdata_o), .x_mem_result_err_o(x_mem_result_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected result.
  always @(negedge clk_i) begin
    if (!rst_i && x_mem_result_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d with nothing expected", x_mem_result_id_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_id", 32'(x_mem_result_id_o), 32'(e.id));
        chk("result_rdata", x_mem_result_rdata_o, e.rdata);
        chk("result_err", 32'(x_mem_result_err_o), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata);
    x_mem_valid_i     = 1'b1;
    x_mem_req_id_i    = id;
    x_mem_req_addr_i  = addr;
    x_mem_req_we_i    = we;
    x_mem_req_be_i    = 4'hF;
    x_mem_req_wdata_i = wdata;
  endtask

  task automatic rvalid(input logic [31:0] rdata, input logic err, input logic exp_vld,
                        input logic [3:0] exp_id, input logic [31:0] exp_rdata);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = err;
    if (exp_vld) exp_q.push_back('{id: exp_id, rdata: exp_rdata, err: err});
  endtask

  task automatic bus_idle();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    x_mem_valid_i = 1'b0; x_mem_req_id_i = '0; x_mem_req_addr_i = '0; x_mem_req_we_i = 1'b0;
    x_mem_req_be_i = '0; x_mem_req_wdata_i = '0; x_mem_req_last_i = 1'b1; x_mem_req_spec_i = 1'b0;
    bus_idle();
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_ready", 32'(x_mem_ready_o), 32'd1);
    chk("rst_req", 32'(data_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_prot", 32'(protocol_err_o), 32'd0);
    chk("rst_res_vld", 32'(x_mem_result_valid_o), 32'd0);
    chk("rst_res_id", 32'(x_mem_result_id_o), 32'd0);
    chk("rst_res_rdata", x_mem_result_rdata_o, 32'd0);
    chk("rst_res_err", 32'(x_mem_result_err_o), 32'd0);

    // Load, immediate grant, rvalid two cycles later.
    drive_req(4'd3, 32'h100, 1'b0, 32'h0);
    tick();
    x_mem_valid_i = 1'b0;
    chk("ld_req", 32'(data_req_o), 32'd1);
    chk("ld_addr", data_addr_o, 32'h100);
    chk("ld_we", 32'(data_we_o), 32'd0);
    chk("ld_ready", 32'(x_mem_ready_o), 32'd0);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    chk("ld_req_done", 32'(data_req_o), 32'd0);
    chk("ld_busy", 32'(busy_o), 32'd1);
    tick();
    rvalid(32'hDEADBEEF, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF);
    tick();
    bus_idle();
    chk("ld_busy_after", 32'(busy_o), 32'd0);

    // Store with grant in the fourth REQ cycle; bus outputs must hold steady.
    drive_req(4'd5, 32'h200, 1'b1, 32'hCAFEF00D);
    tick();
    x_mem_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_req", 32'(data_req_o), 32'd1);
      chk("st_addr", data_addr_o, 32'h200);
      chk("st_we", 32'(data_we_o), 32'd1);
      chk("st_be", 32'(data_be_o), 32'hF);
      chk("st_wdata", data_wdata_o, 32'hCAFEF00D);
      chk("st_ready", 32'(x_mem_ready_o), 32'd0);
      if (i == 3) data_gnt_i = 1'b1;
      tick();
    end
    data_gnt_i = 1'b0;
    chk("st_req_done", 32'(data_req_o), 32'd0);
    rvalid(32'h12345678, 1'b0, 1'b1, 4'd5, 32'h0);
    tick();
    bus_idle();

    // Two outstanding fill the limit; a third request waits for the first response.
    drive_req(4'd1, 32'h300, 1'b0, 32'h0);
    tick();
    x_mem_valid_i = 1'b0; data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    drive_req(4'd2, 32'h304, 1'b0, 32'h0);
    tick();
    x_mem_valid_i = 1'b0; data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    drive_req(4'd7, 32'h308, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", 32'(x_mem_ready_o), 32'd0);
      chk("full_req", 32'(data_req_o), 32'd0);
      tick();
    end
    rvalid(32'h11, 1'b0, 1'b1, 4'd1, 32'h11);
    tick();
    bus_idle();
    chk("drain_ready", 32'(x_mem_ready_o), 32'd1);
    tick();
    x_mem_valid_i = 1'b0;
    chk("third_req", 32'(data_req_o), 32'd1);
    chk("third_addr", data_addr_o, 32'h308);
    // Grant of the third coincides with the response for the second.
    data_gnt_i = 1'b1;
    rvalid(32'h22, 1'b0, 1'b1, 4'd2, 32'h22);
    tick();
    bus_idle();
    chk("same_cyc_busy", 32'(busy_o), 32'd1);
    chk("same_cyc_ready", 32'(x_mem_ready_o), 32'd1);
    rvalid(32'h77, 1'b0, 1'b1, 4'd7, 32'h77);
    tick();
    bus_idle();
    chk("same_cyc_idle", 32'(busy_o), 32'd0);

    // Bus error, then a spurious response while idle.
    drive_req(4'd9, 32'h400, 1'b0, 32'h0);
    tick();
    x_mem_valid_i = 1'b0; data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    rvalid(32'hBAD, 1'b1, 1'b1, 4'd9, 32'hBAD);
    tick();
    bus_idle();
    chk("err_no_prot", 32'(protocol_err_o), 32'd0);
    rvalid(32'h55, 1'b0, 1'b0, 4'd0, 32'h0);
    tick();
    bus_idle();
    chk("spur_prot", 32'(protocol_err_o), 32'd1);
    tick(); tick();
    chk("spur_prot_sticky", 32'(protocol_err_o), 32'd1);

    // Reset while in REQ with one outstanding, then a late response.
    drive_req(4'd4, 32'h500, 1'b0, 32'h0);
    tick();
    x_mem_valid_i = 1'b0; data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    drive_req(4'd6, 32'h504, 1'b0, 32'h0);
    tick();
    x_mem_valid_i = 1'b0;
    chk("pre_rst_req", 32'(data_req_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_req", 32'(data_req_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_ready", 32'(x_mem_ready_o), 32'd1);
    chk("mid_rst_prot", 32'(protocol_err_o), 32'd0);
    rvalid(32'h66, 1'b0, 1'b0, 4'd0, 32'h0);
    tick();
    bus_idle();
    chk("late_rvalid_prot", 32'(protocol_err_o), 32'd1);
    tick(); tick();

    chk("results_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
